// File: rtl/membrane_state_sequencer.sv
// Time-multiplexes N_NEURONS neurons onto one combinational neuron datapath,
// storing each neuron's membrane and spike flag. Optional macro: SPIKE_COUNT_EN.
module membrane_state_sequencer #(
    parameter int n_stage   = 2,
    parameter int N_NEURONS = 4,
    localparam int MW       = n_stage + 2,
    localparam int IDX_W    = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 clear,
    output logic                 busy,
    output logic                 done,
    output logic [IDX_W-1:0]     neuron_idx,
    output logic signed [MW-1:0] last_membrane,
    output logic                 was_spike,
    input  logic signed [MW-1:0] new_membrane,
    input  logic                 is_spike,
    output logic [N_NEURONS-1:0] spike_vector,
    output logic [7:0]           spike_count,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic signed [MW-1:0]  mem_q [N_NEURONS];
    logic [N_NEURONS-1:0]  spk_q;
    logic [N_NEURONS-1:0]  pending_q;
    logic [N_NEURONS-1:0]  spike_vector_q;
    logic                  last_idx;

    assign last_idx = (idx_q == IDX_W'(N_NEURONS - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear takes priority over start in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!clear && start) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (last_idx) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            SCAN: busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    always_comb begin
        idx_d = idx_q;
        case (state_q)
            IDLE:    idx_d = '0;
            SCAN:    idx_d = last_idx ? '0 : idx_q + 1'b1;
            default: idx_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    // Per-neuron storage: written once per SCAN cycle at the current index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                mem_q[i] <= '0;
            end
            spk_q          <= '0;
            pending_q      <= '0;
            spike_vector_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clear) begin
                        for (int i = 0; i < N_NEURONS; i++) begin
                            mem_q[i] <= '0;
                        end
                        spk_q <= '0;
                    end
                end
                SCAN: begin
                    mem_q[idx_q]     <= new_membrane;
                    spk_q[idx_q]     <= is_spike;
                    pending_q[idx_q] <= is_spike;
                end
                DONE: spike_vector_q <= pending_q;
                default: ;
            endcase
        end
    end

    assign neuron_idx    = idx_q;
    assign last_membrane = mem_q[idx_q];
    assign was_spike     = spk_q[idx_q];
    assign spike_vector  = spike_vector_q;
    assign state_dbg     = state_q;

`ifdef SPIKE_COUNT_EN
    logic [7:0] count_q;
    logic [4:0] pop;
    logic [8:0] sum;

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            pop = pop + 5'(pending_q[i]);
        end
        sum = {1'b0, count_q} + 9'(pop);
    end

    // Saturating accumulate once per completed timestep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (state_q == IDLE && clear) begin
            count_q <= '0;
        end else if (state_q == DONE) begin
            count_q <= sum[8] ? 8'hFF : sum[7:0];
        end
    end

    assign spike_count = count_q;
`else
    assign spike_count = 8'd0;
`endif

endmodule

// File: tb/tb_membrane_state_sequencer.sv
// Scoreboard bench for membrane_state_sequencer (N_NEURONS=4, MW=4).
module tb_membrane_state_sequencer;

    localparam int N  = 4;
    localparam int MW = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 clear = 1'b0;
    logic                 busy, done, was_spike, is_spike;
    logic [1:0]           neuron_idx;
    logic signed [MW-1:0] last_membrane, new_membrane;
    logic [N-1:0]         spike_vector;
    logic [7:0]           spike_count;
    logic [1:0]           state_dbg;

    int mode = 0;
    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    // Scan reads {idx, membrane, spike}; done results {count, spike_vector}
    logic [6:0]  exp_q[$];
    logic [11:0] exp_sv_q[$];

    logic signed [MW-1:0] m_mem [N];
    logic [N-1:0]         m_spk;
    logic [N-1:0]         m_sv;
    int                   m_cnt;

    membrane_state_sequencer #(.n_stage(2), .N_NEURONS(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .busy(busy), .done(done), .neuron_idx(neuron_idx),
        .last_membrane(last_membrane), .was_spike(was_spike),
        .new_membrane(new_membrane), .is_spike(is_spike),
        .spike_vector(spike_vector), .spike_count(spike_count),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Neuron datapath model
    always_comb begin
        new_membrane = '0;
        is_spike     = 1'b0;
        case (mode)
            0: begin
                new_membrane = $signed(4'(neuron_idx) + 4'd1);
                is_spike     = (neuron_idx == 2'd2);
            end
            1: begin
                new_membrane = last_membrane + 4'sd1;
                is_spike     = (neuron_idx == 2'd3);
            end
            default: begin
                new_membrane = last_membrane;
                is_spike     = 1'b1;
            end
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < N; i++) m_mem[i] = '0;
        m_spk = '0;
    endtask

    // Pushes the expected reads and result of one full timestep in mode m
    task automatic push_step(input int m);
        logic [N-1:0] pend;
        int pc;
        pend = '0;
        pc = 0;
        for (int i = 0; i < N; i++) begin
            exp_q.push_back({2'(i), m_mem[i], m_spk[i]});
            case (m)
                0: begin m_mem[i] = 4'(i + 1);       pend[i] = (i == 2); end
                1: begin m_mem[i] = m_mem[i] + 4'sd1; pend[i] = (i == 3); end
                default: pend[i] = 1'b1;
            endcase
            m_spk[i] = pend[i];
            pc += int'(pend[i]);
        end
        m_sv = pend;
`ifdef SPIKE_COUNT_EN
        m_cnt = (m_cnt + pc > 255) ? 255 : m_cnt + pc;
`endif
        exp_sv_q.push_back({8'(m_cnt), m_sv});
    endtask

    task automatic run_step(input int m, input bit inject);
        int cyc;
        bit seen;
        push_step(m);
        mode = m;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                start = (inject && cyc == 2);
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        check("done_latency", cyc, 5);
        @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_idx"}, neuron_idx, 0);
        check({tag, "_sv"}, spike_vector, 0);
        check({tag, "_mem"}, last_membrane, 0);
        check({tag, "_spk"}, was_spike, 0);
        check({tag, "_cnt"}, spike_count, 0);
        check({tag, "_state"}, state_dbg, 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a read or a done
    initial begin
        logic [6:0]  e;
        logic [11:0] d;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (busy && !done) begin
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_scan: idx %0d, none expected", neuron_idx);
                    end else begin
                        e = exp_q.pop_front();
                        check("scan_read", {neuron_idx, last_membrane, was_spike}, e);
                    end
                end
                if (done) begin
                    done_cnt++;
                    check("done_busy", busy, 1);
                    check("done_idx", neuron_idx, 0);
                    if (exp_sv_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_done: got done, none expected");
                    end else begin
                        d = exp_sv_q.pop_front();
                        @(posedge clk); #1;
                        check("spike_vector", spike_vector, d[3:0]);
                        check("spike_count", spike_count, d[11:4]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        m_cnt = 0;
        m_sv = '0;
        model_zero();
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // Basic timestep, then echo timestep reading back stored membranes
        run_step(0, 1'b0);
        run_step(1, 1'b0);

        // start together with clear: clear wins, spike_vector kept
        @(negedge clk); start = 1'b1; clear = 1'b1;
        @(negedge clk); start = 1'b0; clear = 1'b0;
        model_zero();
`ifdef SPIKE_COUNT_EN
        m_cnt = 0;
`endif
        for (int i = 0; i < 4; i++) begin
            check("clear_no_busy", busy, 0);
            @(negedge clk);
        end
        check("clear_keeps_sv", spike_vector, m_sv);
        run_step(0, 1'b0);

        // start during SCAN is dropped
        d0 = done_cnt;
        run_step(0, 1'b1);
        repeat (8) @(negedge clk);
        check("inject_no_busy", busy, 0);
        check("inject_one_done", done_cnt - d0, 1);

        // Asynchronous reset at idx 2
        mode = 1;
        for (int i = 0; i < 3; i++) exp_q.push_back({2'(i), m_mem[i], m_spk[i]});
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("async_rst");
        model_zero();
        m_sv = '0;
        m_cnt = 0;
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        check("rst_no_done", done_cnt - d0, 0);
        rst_n = 1'b1;
        run_step(0, 1'b0);

`ifdef SPIKE_COUNT_EN
        for (int s = 0; s < 64; s++) run_step(2, 1'b0);
        check("count_saturated", spike_count, 255);
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        check("count_cleared", spike_count, 0);
`else
        run_step(2, 1'b0);
        check("count_disabled", spike_count, 0);
`endif

        repeat (3) @(negedge clk);
        check("scan_queue_empty", exp_q.size(), 0);
        check("done_queue_empty", exp_sv_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/membrane_state_sequencer.md
MEMBRANE_STATE_SEQUENCER -- requirements
Module: membrane_state_sequencer

Interface
REQ-001 Parameter n_stage, default 2, sets synapse-tree depth; membrane width MW = n_stage+2 bits, signed.
REQ-002 Parameter N_NEURONS, default 4, is the number of neurons time-multiplexed onto one neuron datapath; legal range 2..16.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  timestep request, sampled only in IDLE.
REQ-006 clear  input  1  zero all stored membranes and spike flags, sampled only in IDLE.
REQ-007 busy  output  1  high in SCAN and DONE.
REQ-008 done  output  1  one-cycle pulse, timestep complete.
REQ-009 neuron_idx  output  $clog2(N_NEURONS)  index of the neuron being evaluated.
REQ-010 last_membrane  output  MW signed  stored membrane of neuron_idx, to the neuron datapath.
REQ-011 was_spike  output  1  stored spike flag of neuron_idx, to the neuron datapath.
REQ-012 new_membrane  input  MW signed  updated membrane from the neuron datapath.
REQ-013 is_spike  input  1  spike result from the neuron datapath.
REQ-014 spike_vector  output  N_NEURONS  spikes of the last completed timestep, bit i = neuron i.
REQ-015 spike_count  output  8  saturating total spike count (see Configuration).

Function
REQ-016 FSM states IDLE, SCAN, DONE; reset state IDLE.
REQ-017 IDLE: clear=1 -> zero the membrane and spike arrays, stay IDLE; else start=1 -> neuron_idx<=0, go SCAN; else hold.
REQ-018 clear and start high in the same IDLE cycle -> clear wins, start dropped, no scan.
REQ-019 start and clear in SCAN or DONE are ignored, not queued.
REQ-020 last_membrane/was_spike are combinational reads of the arrays at neuron_idx; the neuron datapath is purely combinational, so new_membrane/is_spike are valid in the same cycle.
REQ-021 Each SCAN cycle: mem[idx]<=new_membrane, spk[idx]<=is_spike, pending[idx]<=is_spike, idx<=idx+1.
REQ-022 In SCAN with idx=N_NEURONS-1: write as in REQ-021, idx<=0 (no wrap past N-1), go DONE.
REQ-023 DONE: spike_vector<=pending, done=1 for exactly this cycle, go IDLE.
REQ-024 Latency: start sampled at edge k -> SCAN occupies cycles k+1..k+N_NEURONS -> done high in cycle k+N_NEURONS+1; next start is accepted no earlier than edge k+N_NEURONS+2.
REQ-025 spike_vector is stable between DONE cycles; clear does not alter it.
REQ-026 new_membrane is stored unmodified at MW bits; no sign extension or saturation in this block.
REQ-027 neuron_idx holds 0 in IDLE and DONE; last_membrane/was_spike then show neuron 0.

Reset
REQ-028 rst_n low, at any time including mid-SCAN, immediately forces: state IDLE, neuron_idx 0, all mem entries 0, all spk entries 0, pending 0, spike_vector 0, done 0, busy 0, spike_count 0.
REQ-029 After rst_n deassertion, the first start is accepted on the first rising edge at which it is sampled high.

Configuration
REQ-030 Macro SPIKE_COUNT_EN: when defined, the DONE cycle adds popcount(pending) to spike_count, saturating at 255; clear resets it to 0.
REQ-031 Without SPIKE_COUNT_EN: spike_count is constant 0 and no counter logic is synthesised; all other behaviour is unchanged.

Verification
REQ-032 Reset, then start pulse, N=4, model returns new_membrane=idx+1, is_spike=(idx==2) -> busy for 5 cycles, done in cycle 5 after start, spike_vector=4'b0100, mem={1,2,3,4}.
REQ-033 Second timestep, model echoes last_membrane+1 -> observed last_membrane sequence 1,2,3,4; was_spike high only at idx 2.
REQ-034 start and clear high together in IDLE -> no busy; all last_membrane reads 0 on the next scan; spike_vector unchanged.
REQ-035 start pulsed during SCAN cycle 2 -> ignored; exactly one done; no second scan.
REQ-036 rst_n low during SCAN at idx=2 -> outputs zero asynchronously, state IDLE, no done pulse.
REQ-037 SPIKE_COUNT_EN defined, all 4 neurons spike every step for 64 steps -> spike_count saturates at 255; clear then gives 0; undefined -> spike_count stays 0.
